// File: rtl/seq_mult_pkg.sv
// Shared constants and controller state encoding for the 6x6 sequential multiplier slice.
package seq_mult_pkg;

  localparam int unsigned MULT_W   = 6;
  localparam int unsigned MULT_LAT = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } issue_state_t;

endpackage

// File: rtl/mult_operand_buf.sv
// One-entry valid/ready holding register; a push and a pop on the same edge reloads the entry.
module mult_operand_buf
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * MULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             full;
  logic [WIDTH-1:0] data;

  assign in_ready  = rst | ~full | out_ready;
  assign out_valid = full;
  assign out_data  = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// 6x6 unsigned right-shift sequential multiplier; rst loads the operands, then W add/shift steps.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned W = MULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]   mcand;
  logic [2*W-1:0] p;
  logic [CW-1:0]  cnt;
  logic [W:0]     sum;

  // Upper half accumulates the multiplicand when the low multiplier bit is set; carry shifts in.
  always_comb begin
    sum = {1'b0, p[2*W-1:W]} + {1'b0, (p[0] ? mcand : {W{1'b0}})};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= a;
      p     <= {{W{1'b0}}, b};
      cnt   <= '0;
    end else if (cnt != CW'(W)) begin
      p   <= {sum, p[W-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

  assign product = p;

endmodule

// File: rtl/seq_mult_issue_ctrl.sv
// Issue controller: queues one operand pair, pulses the multiplier load, waits its latency,
// and returns the captured product over a valid/ready handshake.
module seq_mult_issue_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned W        = seq_mult_pkg::MULT_W,
  parameter int unsigned MULT_LAT = seq_mult_pkg::MULT_LAT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           mult_start,
  output logic [W-1:0]   mult_a,
  output logic [W-1:0]   mult_b,
  input  logic [2*W-1:0] mult_product,
  output logic           busy
);

  localparam int unsigned CNT_W = $clog2(MULT_LAT + 1);

  issue_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic           start_nxt, valid_nxt;
  logic [W-1:0]   a_nxt, b_nxt;
  logic [2*W-1:0] prod_nxt;

  logic           buf_valid, pop;
  logic [2*W-1:0] buf_data;

  mult_operand_buf #(
    .WIDTH (2 * W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_a, in_b}),
    .out_valid (buf_valid),
    .out_ready (pop),
    .out_data  (buf_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    a_nxt     = mult_a;
    b_nxt     = mult_b;
    valid_nxt = out_valid;
    prod_nxt  = out_product;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (buf_valid) begin
          pop       = 1'b1;
          state_nxt = ST_LAUNCH;
          start_nxt = 1'b1;
          {a_nxt, b_nxt} = buf_data;
        end
      end
      ST_LAUNCH: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(MULT_LAT - 1)) begin
          prod_nxt  = mult_product;
          valid_nxt = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          // A queued pair launches on the handshake edge itself, skipping IDLE.
          if (buf_valid) begin
            pop       = 1'b1;
            state_nxt = ST_LAUNCH;
            start_nxt = 1'b1;
            {a_nxt, b_nxt} = buf_data;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mult_start  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mult_start  <= start_nxt;
      mult_a      <= a_nxt;
      mult_b      <= b_nxt;
      out_valid   <= valid_nxt;
      out_product <= prod_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_seq_mult_issue_ctrl.sv
// Directed bench: issue controller driving the real sequential multiplier.
module tb_seq_mult_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_product;
  logic        mult_start;
  logic [5:0]  mult_a, mult_b;
  logic [11:0] mult_product;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_mult_issue_ctrl #(.W(6), .MULT_LAT(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_product (mult_product),
    .busy         (busy)
  );

  seq_mult #(.W(6)) u_mult (
    .clk     (clk),
    .rst     (mult_start),
    .a       (mult_a),
    .b       (mult_b),
    .product (mult_product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Ticks until out_valid is seen; n is the number of ticks taken (capped at 40).
  task automatic wait_valid(output int n, output int starts);
    n = 0;
    starts = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (mult_start === 1'b1) starts++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] a, input logic [5:0] b,
                        input logic [11:0] prod);
    int n, starts;
    in_valid = 1'b1; in_a = a; in_b = b;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_valid(n, starts);
    chk({tag, "_latency"}, 32'(n + 1), 32'd10);
    chk({tag, "_start_pulses"}, 32'(starts), 32'd1);
    chk({tag, "_product"}, 32'(out_product), 32'(prod));
    tick();
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, starts, seen_valid, seen_start;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #1;
    chk("reset_in_ready_cycle0", 32'(in_ready), 32'd1);
    tick();
    tick();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_product", 32'(out_product), 32'd0);
    chk("reset_mult_start", 32'(mult_start), 32'd0);
    chk("reset_mult_ab", 32'({mult_a, mult_b}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // 1 and 2: single operations
    run_op("op_6x7", 6'd6, 6'd7, 12'd42);
    run_op("op_63x63", 6'd63, 6'd63, 12'd3969);
    run_op("op_0x45", 6'd0, 6'd45, 12'd0);

    // 3: back-to-back, second pair accepted during WAIT
    in_valid = 1'b1; in_a = 6'd5; in_b = 6'd9;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("b2b_busy_wait", 32'(busy), 32'd1);
    in_valid = 1'b1; in_a = 6'd12; in_b = 6'd11;
    chk("b2b_second_ready", 32'(in_ready), 32'd1);
    tick();
    in_a = 6'd1; in_b = 6'd1;
    chk("b2b_third_blocked", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("b2b_still_blocked", 32'(in_ready), 32'd0);
    wait_valid(n, starts);
    chk("b2b_first_at_cycle10", 32'(n + 6), 32'd10);
    chk("b2b_first_product", 32'(out_product), 32'd45);
    tick();
    chk("b2b_relaunch_start", 32'(mult_start), 32'd1);
    chk("b2b_relaunch_ab", 32'({mult_a, mult_b}), 32'({6'd12, 6'd11}));
    chk("b2b_valid_drop", 32'(out_valid), 32'd0);
    wait_valid(n, starts);
    chk("b2b_second_latency", 32'(n), 32'd8);
    chk("b2b_second_product", 32'(out_product), 32'd132);
    tick();
    chk("b2b_idle", 32'(busy), 32'd0);

    // 4: backpressure with a queued pair
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 6'd4; in_b = 6'd5;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1; in_a = 6'd3; in_b = 6'd3;
    tick();
    in_valid = 1'b0;
    wait_valid(n, starts);
    chk("bp_first_at_cycle10", 32'(n + 5), 32'd10);
    chk("bp_product", 32'(out_product), 32'd20);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_product", 32'(out_product), 32'd20);
      chk("bp_no_relaunch", 32'(mult_start), 32'd0);
      chk("bp_buf_full", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_launch_start", 32'(mult_start), 32'd1);
    chk("bp_launch_ab", 32'({mult_a, mult_b}), 32'({6'd3, 6'd3}));
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    wait_valid(n, starts);
    chk("bp_second_latency", 32'(n), 32'd8);
    chk("bp_second_product", 32'(out_product), 32'd9);
    tick();

    // 5: reset during WAIT with a queued pair
    in_valid = 1'b1; in_a = 6'd2; in_b = 6'd3;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_a = 6'd7; in_b = 6'd7;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_mult_start", 32'(mult_start), 32'd0);
    seen_valid = 0; seen_start = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1) seen_valid++;
      if (mult_start === 1'b1) seen_start++;
    end
    chk("rst_mid_no_result", 32'(seen_valid), 32'd0);
    chk("rst_mid_no_launch", 32'(seen_start), 32'd0);

    // 6: accept on the launch edge from IDLE with a full buffer
    in_valid = 1'b1; in_a = 6'd2; in_b = 6'd5;
    tick();
    in_a = 6'd6; in_b = 6'd6;
    chk("sim_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("sim_launch_start", 32'(mult_start), 32'd1);
    chk("sim_launch_old_ab", 32'({mult_a, mult_b}), 32'({6'd2, 6'd5}));
    wait_valid(n, starts);
    chk("sim_first_latency", 32'(n), 32'd8);
    chk("sim_first_product", 32'(out_product), 32'd10);
    tick();
    chk("sim_second_launch_ab", 32'({mult_a, mult_b}), 32'({6'd6, 6'd6}));
    wait_valid(n, starts);
    chk("sim_second_latency", 32'(n), 32'd8);
    chk("sim_second_product", 32'(out_product), 32'd36);
    tick();
    chk("sim_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mult_issue_ctrl.md
Name: seq_mult_issue_ctrl

Overview:
- Upstream/downstream wrapper stage for the 6x6 unsigned right-shift sequential multiplier.
- Accepts operand pairs over a valid/ready handshake and launches the multiplier by pulsing its synchronous start/reset input.
- Waits the multiplier's fixed latency, captures the 12-bit product, and presents it over a valid/ready output handshake.
- Holds one queued operand pair so the next operation can be accepted while the current one is in flight.

Parameters:
- W, 6, operand width; product width is 2*W.
- MULT_LAT, 7, cycles from the cycle after the launch pulse to the cycle in which mult_product is final (1 load + W iterations).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept an operand pair
- in_a  input  W  multiplicand
- in_b  input  W  multiplier
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_product  output  2*W  captured product
- mult_start  output  1  drives the multiplier's rst (load) input; one-cycle pulse
- mult_a  output  W  to multiplier a
- mult_b  output  W  to multiplier b
- mult_product  input  2*W  from multiplier product
- busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset is clk, synchronous active-high rst. All outputs are registered. On reset:
  - in_ready=1 (asserted combinationally from the empty hold buffer; reads 1 in reset cycle).
  - out_valid=0, out_product=0, mult_start=0, mult_a=0, mult_b=0, busy=0.
  - FSM=IDLE, hold buffer empty, latency counter=0.
- Reset mid-operation: the in-flight and queued operations are discarded with no output. The multiplier is not re-pulsed.
- Input acceptance:
  - Input handshake fires on in_valid & in_ready at a rising edge.
  - in_ready = hold buffer empty.
  - An accepted pair is written to the hold buffer.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
  - IDLE: if the hold buffer is full, go to LAUNCH. The buffer pair is moved to mult_a/mult_b, the buffer is freed, and mult_start=1 for exactly one cycle.
  - LAUNCH: lasts 1 cycle. mult_a/mult_b stay stable. Next state is WAIT with counter=0, and mult_start returns to 0.
  - WAIT: counter increments each cycle. In the cycle where counter==MULT_LAT-1, the next edge latches mult_product into out_product, sets out_valid=1, and goes to DONE.
  - DONE: out_valid and out_product hold until out_ready=1. On the handshake edge:
    - if the buffer is full: go directly to LAUNCH (back-to-back launch, no IDLE bubble);
    - otherwise go to IDLE.
    - out_valid drops in both cases.
- Timing: launch cycle T; result visible with out_valid=1 in cycle T+MULT_LAT+1 (default T+8).
  - Minimum input-accept to out_valid from IDLE with an empty buffer: 10 cycles (accept edge, IDLE, LAUNCH, 7 WAIT).
- The hold buffer accepts during LAUNCH/WAIT/DONE, enabling overlap. With the buffer full, in_ready=0 until the next launch frees it.
- Simultaneous events:
  - Input accept and launch from the buffer on the same edge are legal. The launch reads the old entry and the buffer reloads with the new one, so in_ready stays 1.
  - out_ready held high: throughput is one result per MULT_LAT+2 cycles.
- mult_a/mult_b change only on the edge entering LAUNCH.
- Arithmetic: no arithmetic in this block. out_product is a verbatim 2*W capture with no truncation.

Decomposition:
- Shared package seq_mult_pkg holds:
  - constants MULT_W=6 and MULT_LAT=7;
  - FSM state encoding (2-bit IDLE=0, LAUNCH=1, WAIT=2, DONE=3).
- One natural sub-module, mult_operand_buf: a 1-entry valid/ready holding register of width 2*W.
- The FSM, counter and output register remain in seq_mult_issue_ctrl.
- The bench instantiates the real multiplier connected to mult_* ports.

Test Plan:
1. Single op: in_a=6, in_b=7 accepted at cycle 0, out_ready=1. Required: out_valid in cycle 10, out_product=42, mult_start high exactly one cycle.
2. Max operands: a=63, b=63. Required: out_product=3969. Then a=0, b=45. Required: out_product=0.
3. Back-to-back: pairs (5,9) and (12,11) offered consecutively. Required: second accepted during WAIT, in_ready low for a third pair, results 45 then 132, and second launch on the edge after the first output handshake.
4. Backpressure: out_ready=0 for 5 cycles after out_valid with result 20 (4x5). Required: out_product and out_valid stable, no relaunch until handshake; the queued pair (3,3) then yields 9.
5. Reset mid-operation: assert rst in WAIT cycle 3 with a queued pair. Required: next cycle shows out_valid=0, busy=0, in_ready=1, mult_start=0, and no result ever appears for either pair.
6. Simultaneous: in IDLE with a full buffer, a new in_valid arrives. Required: it is accepted on the launch edge and in_ready never drops.
